seg_scan: RTL and testbench

Two-digit, time-multiplexed seven-segment driver that sits directly downstream of the binary-to-decimal converter in the adder datapath. It captures the converter's tens and ones BCD digits on a load strobe and scans them onto a shared active-low segment bus with per-digit active-low enables. A guard gap between digits prevents ghosting. Leading-zero blanking is optional.

---
 rtl/seg_scan.sv | 139 +++++++++++++
 tb/tb_seg_scan.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Two-digit multiplexed seven-segment driver: holds a BCD tens/ones pair and
// scans it onto an active-low segment bus with a blank guard gap between digits.
module seg_scan #(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 1000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       tick
);

    localparam int MAXN = (PRESCALE > GUARD) ? PRESCALE : GUARD;
    localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;

    localparam logic [CW-1:0] PRE_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_GAP1 = 2'd1,
        S_TENS = 2'd2,
        S_GAP0 = 2'd3
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] count_reg;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          tick_reg;
    logic          slot_last;
    logic          lit_state;

    // BCD to active-low gfedcba; non-decimal codes show a dash.
    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    assign lit_state = (state_reg == S_ONES) || (state_reg == S_TENS);
    assign slot_last = lit_state ? (count_reg == PRE_LAST) : (count_reg == GUARD_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_ONES;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (slot_last) begin
            case (state_reg)
                S_ONES:  state_next = S_GAP1;
                S_GAP1:  state_next = S_TENS;
                S_TENS:  state_next = S_GAP0;
                S_GAP0:  state_next = S_ONES;
                default: state_next = S_ONES;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else if (slot_last) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Loads never touch the counter, so slot boundaries stay fixed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else if (load) begin
            tens_q <= tens;
            ones_q <= ones;
        end
    end

    // Registered so it rises in the same cycle the new lit slot appears.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= slot_last && ((state_reg == S_GAP0) || (state_reg == S_GAP1));
        end
    end

    assign tick = tick_reg;

    always_comb begin
        an  = 2'b11;
        seg = SEG_OFF;
        case (state_reg)
            S_ONES: begin
                an  = 2'b10;
                seg = dec(ones_q);
            end
            S_TENS: begin
                if (!(blank_lz && (tens_q == 4'd0))) begin
                    an  = 2'b01;
                    seg = dec(tens_q);
                end
            end
            default: begin
                an  = 2'b11;
                seg = SEG_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with PRESCALE=4, GUARD=1 (10-cycle scan period).
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       resetn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       tick;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D3 = 7'b0110000;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] D8 = 7'b0000000;
    localparam logic [6:0] D9 = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] OFF  = 7'b1111111;

    seg_scan #(.PRESCALE(4), .GUARD(1)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .tens     (tens),
        .ones     (ones),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .tick     (tick)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] exp_an,
                             input logic [6:0] exp_seg, input logic exp_tick);
        check({tag, ".an"},   {6'd0, an},   {6'd0, exp_an});
        check({tag, ".seg"},  {1'b0, seg},  {1'b0, exp_seg});
        check({tag, ".tick"}, {7'd0, tick}, {7'd0, exp_tick});
    endtask

    // Starts in the last gap cycle; covers the next 10 edges, ending in the gap again.
    task automatic scan_period(input string tag, input logic [6:0] ones_seg,
                               input logic [1:0] tens_an, input logic [6:0] tens_seg);
        for (int ph = 0; ph < 10; ph++) begin
            step();
            load = 1'b0;
            if (ph < 4)      check_out(tag, 2'b10, ones_seg, ph == 0);
            else if (ph < 5) check_out(tag, 2'b11, OFF, 1'b0);
            else if (ph < 9) check_out(tag, tens_an, tens_seg, ph == 5);
            else             check_out(tag, 2'b11, OFF, 1'b0);
        end
        $display("period %s: ones_seg=%b tens_an=%b tens_seg=%b", tag, ones_seg, tens_an, tens_seg);
    endtask

    initial begin
        // Reset with the clock stopped.
        #3;
        check_out("rst_stopped", 2'b10, D0, 1'b0);
        #2;
        resetn = 1'b1;
        #2;
        clk_en = 1'b1;
        check_out("first_ones_pre", 2'b10, D0, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i <= 3)      check_out("first_ones", 2'b10, D0, 1'b0);
            else if (i == 4) check_out("first_gap1", 2'b11, OFF, 1'b0);
            else if (i <= 8) check_out("first_tens", 2'b01, D0, i == 5);
            else             check_out("first_gap0", 2'b11, OFF, 1'b0);
        end
        $display("first period after reset done");

        load = 1'b1; tens = 4'd1; ones = 4'd5;
        scan_period("t1_o5_a", D5, 2'b01, D1);
        scan_period("t1_o5_b", D5, 2'b01, D1);

        load = 1'b1; tens = 4'd0; ones = 4'd7; blank_lz = 1'b1;
        scan_period("t0_o7_blank", D7, 2'b11, OFF);
        blank_lz = 1'b0;
        scan_period("t0_o7_noblank", D7, 2'b01, D0);

        load = 1'b1; tens = 4'hC; ones = 4'hA;
        scan_period("dash", DASH, 2'b01, DASH);

        load = 1'b1; tens = 4'd9; ones = 4'd3;
        scan_period("t9_o3", D3, 2'b01, D9);

        // Mid-slot load during the second cycle of S_ONES.
        step();
        check_out("mid_ph0", 2'b10, D3, 1'b1);
        step();
        check_out("mid_ph1", 2'b10, D3, 1'b0);
        load = 1'b1; ones = 4'd8; tens = 4'd9;
        step();
        load = 1'b0;
        check_out("mid_ph2", 2'b10, D8, 1'b0);
        step();
        check_out("mid_ph3", 2'b10, D8, 1'b0);
        step();
        check_out("mid_gap", 2'b11, OFF, 1'b0);
        step();
        check_out("pre_rst_tens", 2'b01, D9, 1'b1);
        $display("mid-slot load done");

        // Asynchronous reset in the middle of S_TENS.
        resetn = 1'b0;
        #1;
        check_out("rst_mid", 2'b10, D0, 1'b0);
        @(negedge clk);
        check_out("rst_hold", 2'b10, D0, 1'b0);
        resetn = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i <= 3)      check_out("rel_ones", 2'b10, D0, 1'b0);
            else if (i == 4) check_out("rel_gap1", 2'b11, OFF, 1'b0);
            else if (i <= 8) check_out("rel_tens", 2'b01, D0, i == 5);
            else             check_out("rel_gap0", 2'b11, OFF, 1'b0);
        end
        $display("reset mid-slot done");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
